mpc_sequencer: RTL and testbench

Microprogram sequencer that sits directly upstream of the control unit in the image-processing CPU. It owns the 8-bit microprogram counter `MPC` that the control unit decodes. It consumes the control unit's jump request (`JMPC`, `Addr`) and the ALU zero flag `Z`, and stalls on memory accesses flagged by `RAM_en`. An optional return stack supports microcode subroutines.

---
 rtl/mpc_sequencer.sv | 164 ++++++++++++++++
 tb/tb_mpc_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mpc_sequencer.sv
// Microprogram sequencer: owns the 8-bit MPC and handles jumps, RAM stalls and halt.
// Optional return stack for microcode subroutines is enabled by defining MPC_RET_STACK_EN.
module mpc_sequencer #(
  parameter logic [7:0] RESET_ADDR  = 8'h00,
  parameter logic [7:0] HALT_ADDR   = 8'hFF,
  parameter int         STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       JMPC,
  input  logic [7:0] Addr,
  input  logic [1:0] jmp_mode,
  input  logic       ret,
  input  logic       Z,
  input  logic       RAM_en,
  input  logic       mem_ready,
  output logic [7:0] MPC,
  output logic       busy,
  output logic       halted,
  output logic       stack_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_MEM, S_HALT} state_t;

  state_t     state_q, state_d;
  logic [7:0] mpc_q, mpc_d;
  logic [7:0] mpc_inc;
  logic       busy_q, halted_q;
  logic       cond_true, take_jmp, advance;

  assign mpc_inc = mpc_q + 8'd1;

  always_comb begin
    case (jmp_mode)
      2'b01:   cond_true = Z;
      2'b10:   cond_true = ~Z;
      default: cond_true = 1'b1;
    endcase
  end
  assign take_jmp = JMPC & cond_true;

`ifdef MPC_RET_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  logic [SPW-1:0] sp_q, sp_d, sp_dec;
  logic [7:0]     stack_mem [2**SPW];
  logic           push_en;
  logic           err_q, err_d;

  assign sp_dec = sp_q - SPW'(1);
`else
  logic unused_ret;
  assign unused_ret = ret;
`endif

  always_comb begin
    state_d = state_q;
    mpc_d   = mpc_q;
    advance = 1'b0;
`ifdef MPC_RET_STACK_EN
    sp_d    = sp_q;
    push_en = 1'b0;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          mpc_d   = RESET_ADDR;
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          mpc_d   = RESET_ADDR;
`ifdef MPC_RET_STACK_EN
          sp_d    = '0;
`endif
        end
      end
      S_RUN: begin
        if (mpc_q == HALT_ADDR)           state_d = S_HALT;
        else if (RAM_en && !mem_ready)    state_d = S_WAIT_MEM;
        else                              advance = 1'b1;
      end
      S_WAIT_MEM: begin
        if (mem_ready) advance = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Shared return/jump/increment path used by RUN and by WAIT_MEM completion.
    if (advance) begin
      state_d = S_RUN;
      mpc_d   = mpc_inc;
`ifdef MPC_RET_STACK_EN
      if (ret) begin
        if (sp_q == '0) begin
          state_d = S_HALT;
          mpc_d   = mpc_q;
          err_d   = 1'b1;
        end else begin
          sp_d  = sp_dec;
          mpc_d = stack_mem[sp_dec];
        end
      end else if (take_jmp) begin
        if (jmp_mode == 2'b11) begin
          if (sp_q == SP_FULL) begin
            state_d = S_HALT;
            mpc_d   = mpc_q;
            err_d   = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SPW'(1);
            mpc_d   = Addr;
          end
        end else begin
          mpc_d = Addr;
        end
      end
`else
      if (take_jmp) mpc_d = Addr;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mpc_q    <= RESET_ADDR;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
`ifdef MPC_RET_STACK_EN
      sp_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mpc_q    <= mpc_d;
      busy_q   <= (state_d == S_RUN) || (state_d == S_WAIT_MEM);
      halted_q <= (state_d == S_HALT);
`ifdef MPC_RET_STACK_EN
      sp_q     <= sp_d;
      err_q    <= err_d;
`endif
    end
  end

`ifdef MPC_RET_STACK_EN
  always_ff @(posedge clk) begin
    if (!rst && push_en) stack_mem[sp_q] <= mpc_inc;
  end
  assign stack_err = err_q;
`else
  assign stack_err = 1'b0;
`endif

  assign MPC    = mpc_q;
  assign busy   = busy_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_mpc_sequencer.sv
// Directed self-checking bench for mpc_sequencer; stack tests follow MPC_RET_STACK_EN.
module tb_mpc_sequencer;
  logic       clk = 1'b0;
  logic       rst, start, JMPC, ret, Z, RAM_en, mem_ready;
  logic [7:0] Addr;
  logic [1:0] jmp_mode;
  logic [7:0] MPC;
  logic       busy, halted, stack_err;
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;

  mpc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .JMPC(JMPC), .Addr(Addr),
    .jmp_mode(jmp_mode), .ret(ret), .Z(Z), .RAM_en(RAM_en),
    .mem_ready(mem_ready), .MPC(MPC), .busy(busy), .halted(halted),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d: MPC=%02h busy=%0b halted=%0b stack_err=%0b", cyc, MPC, busy, halted, stack_err);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_mpc, input logic e_busy,
                         input logic e_halt, input logic e_err);
    chk({tag, ".mpc"}, MPC, e_mpc);
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, e_busy});
    chk({tag, ".halted"}, {7'd0, halted}, {7'd0, e_halt});
    chk({tag, ".err"}, {7'd0, stack_err}, {7'd0, e_err});
  endtask

  task automatic jmp(input logic [1:0] mode, input logic [7:0] a, input logic zf);
    JMPC = 1'b1; jmp_mode = mode; Addr = a; Z = zf;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; JMPC = 1'b0; ret = 1'b0; Z = 1'b0;
    RAM_en = 1'b0; mem_ready = 1'b0; Addr = 8'h00; jmp_mode = 2'b00;
    tick(); tick();
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); chk_all("idle_hold", 8'h00, 1'b0, 1'b0, 1'b0);

    start = 1'b1;
    tick(); chk_all("start", 8'h00, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    tick(); chk("inc1", MPC, 8'h01);
    tick(); chk("inc2", MPC, 8'h02);
    tick(); chk("inc3", MPC, 8'h03);
    tick(); tick(); chk("at05", MPC, 8'h05);

    jmp(2'b01, 8'h40, 1'b1); tick(); chk("jz_taken", MPC, 8'h40);
    jmp(2'b00, 8'h05, 1'b0); tick(); chk("jmp_uncond", MPC, 8'h05);
    jmp(2'b01, 8'h40, 1'b0); tick(); chk("jz_not", MPC, 8'h06);
    jmp(2'b10, 8'h30, 1'b0); tick(); chk("jnz_taken", MPC, 8'h30);
    jmp(2'b10, 8'h44, 1'b1); tick(); chk("jnz_not", MPC, 8'h31);
    JMPC = 1'b0; Addr = 8'h77; tick(); chk("no_jmpc", MPC, 8'h32);

    // RAM stall: MPC=10 visible for four cycles, then 11
    jmp(2'b00, 8'h10, 1'b0); tick(); chk("to10", MPC, 8'h10);
    JMPC = 1'b0; RAM_en = 1'b1; mem_ready = 1'b0;
    tick(); chk_all("stall1", 8'h10, 1'b1, 1'b0, 1'b0);
    tick(); chk("stall2", MPC, 8'h10);
    tick(); chk("stall3", MPC, 8'h10);
    mem_ready = 1'b1;
    tick(); chk("stall_done", MPC, 8'h11);
    tick(); chk("ram_ready_nostall", MPC, 8'h12);
    mem_ready = 1'b0; jmp(2'b00, 8'h50, 1'b0);
    tick(); chk("wait_jmp_hold", MPC, 8'h12);
    mem_ready = 1'b1;
    tick(); chk("wait_jmp_done", MPC, 8'h50);
    RAM_en = 1'b0; mem_ready = 1'b0; JMPC = 1'b0;

`ifdef MPC_RET_STACK_EN
    jmp(2'b00, 8'h20, 1'b0); tick(); chk("to20", MPC, 8'h20);
    jmp(2'b11, 8'h80, 1'b0); tick(); chk_all("call80", 8'h80, 1'b1, 1'b0, 1'b0);
    JMPC = 1'b0; tick(); tick(); chk("at82", MPC, 8'h82);
    ret = 1'b1; tick(); chk("ret21", MPC, 8'h21);
    ret = 1'b0; jmp(2'b11, 8'h90, 1'b0); tick(); chk("call90", MPC, 8'h90);
    ret = 1'b1; jmp(2'b00, 8'h33, 1'b0); tick(); chk("ret_wins", MPC, 8'h22);
    ret = 1'b0;
    for (int i = 0; i < 4; i++) begin
      jmp(2'b11, 8'hA0 + 8'(i), 1'b0); tick(); chk("nest_call", MPC, 8'hA0 + 8'(i));
    end
    jmp(2'b11, 8'hA4, 1'b0); tick(); chk_all("overflow", 8'hA3, 1'b0, 1'b1, 1'b1);
    JMPC = 1'b0; tick(); chk_all("ovf_hold", 8'hA3, 1'b0, 1'b1, 1'b1);
    start = 1'b1; tick(); chk_all("ovf_restart", 8'h00, 1'b1, 1'b0, 1'b1);
    start = 1'b0; rst = 1'b1; tick(); chk_all("rst_clr", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; start = 1'b1; tick(); start = 1'b0;
    ret = 1'b1; tick(); chk_all("underflow", 8'h00, 1'b0, 1'b1, 1'b1);
    ret = 1'b0; start = 1'b1; tick(); chk_all("unf_restart", 8'h00, 1'b1, 1'b0, 1'b1);
    start = 1'b0;
`else
    ret = 1'b1; tick(); chk_all("ret_ignored", 8'h51, 1'b1, 1'b0, 1'b0);
    jmp(2'b11, 8'h60, 1'b0); tick(); chk_all("mode11_jmp", 8'h60, 1'b1, 1'b0, 1'b0);
    ret = 1'b0; jmp(2'b11, 8'h61, 1'b1); tick(); chk("mode11_jmp2", MPC, 8'h61);
`endif

    jmp(2'b00, 8'hFE, 1'b0); tick(); chk("toFE", MPC, 8'hFE);
    JMPC = 1'b0; tick(); chk_all("atFF", 8'hFF, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("halt", 8'hFF, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("halt_hold", 8'hFF, 1'b0, 1'b1, 1'b0);
    start = 1'b1; tick(); chk_all("halt_restart", 8'h00, 1'b1, 1'b0, 1'b0);
    tick(); chk("start_ignored_run", MPC, 8'h01);
    start = 1'b0;

    RAM_en = 1'b1; mem_ready = 1'b0;
    tick(); chk_all("wait_before_rst", 8'h01, 1'b1, 1'b0, 1'b0);
    rst = 1'b1; tick(); chk_all("rst_in_wait", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; RAM_en = 1'b0;
    tick(); chk_all("idle_after_rst", 8'h00, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
